// File: rtl/scope_pkg.sv
// scope_pkg: shared types and helpers for the oscilloscope capture path.
//
// Contents:
//   cap_state_t  - capture sequencer states
//   cap_mode_t   - acquisition mode encoding
//   SLOPE_RISE / SLOPE_FALL - trigger slope encodings
//   decim_div()  - one-hot time-scale to decimation divider mapping
package scope_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_PRIME   = 3'd1,
        ST_ARMED   = 3'd2,
        ST_CAPTURE = 3'd3,
        ST_READOUT = 3'd4
    } cap_state_t;

    // 2'b11 is reserved and is handled exactly like normal mode.
    typedef enum logic [1:0] {
        MODE_NORMAL = 2'b00,
        MODE_SINGLE = 2'b01,
        MODE_AUTO   = 2'b10,
        MODE_RSVD   = 2'b11
    } cap_mode_t;

    localparam logic SLOPE_RISE = 1'b0;
    localparam logic SLOPE_FALL = 1'b1;

    // Divider per one-hot time-scale bit; anything that is not exactly
    // one-hot falls back to no decimation.
    function automatic logic [5:0] decim_div(input logic [5:0] time_scale);
        case (time_scale)
            6'b000001: decim_div = 6'd1;
            6'b000010: decim_div = 6'd2;
            6'b000100: decim_div = 6'd5;
            6'b001000: decim_div = 6'd10;
            6'b010000: decim_div = 6'd20;
            6'b100000: decim_div = 6'd50;
            default:   decim_div = 6'd1;
        endcase
    endfunction

endpackage

// File: rtl/trig_detect.sv
// trig_detect: previous-sample register plus slope comparison against the
// trigger level.
//
// Ports:
//   clk, reset  - clock, asynchronous active-high reset
//   strobe_i    - decimated sample strobe; prev register loads on it
//   sample_i    - current (unsigned) sample
//   level_i     - trigger threshold (unsigned)
//   slope_i     - SLOPE_RISE or SLOPE_FALL
//   hit_o       - combinational, high for the strobe cycle that crosses
//
// The caller decides in which states a hit is meaningful; the prev register
// simply follows every decimated sample.
module trig_detect
    import scope_pkg::*;
#(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              strobe_i,
    input  logic [DATA_W-1:0] sample_i,
    input  logic [DATA_W-1:0] level_i,
    input  logic              slope_i,
    output logic              hit_o
);

    logic [DATA_W-1:0] prev_q;
    logic              prev_below;
    logic              cur_below;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
        end else if (strobe_i) begin
            prev_q <= sample_i;
        end
    end

    assign prev_below = (prev_q < level_i);
    assign cur_below  = (sample_i < level_i);

    always_comb begin
        hit_o = 1'b0;
        if (strobe_i) begin
            if (slope_i == SLOPE_RISE) begin
                hit_o = prev_below & ~cur_below;
            end else begin
                hit_o = ~prev_below & cur_below;
            end
        end
    end

endmodule

// File: rtl/capture_sequencer.sv
// capture_sequencer: sequences one oscilloscope acquisition around the
// shared sample FIFO. Decimates the scaled ADC stream, waits for a trigger
// crossing, writes a fixed-length record into the FIFO, then hands the FIFO
// to the Pi read interface until it is drained.
//
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   sample, sample_valid  - scaled unsigned sample and its one-cycle strobe
//   trig_level, trig_slope- trigger threshold and slope (0 rise, 1 fall)
//   time_scale            - one-hot decimation select
//   mode                  - 00 normal, 01 single, 10 auto, 11 normal
//   arm, abort            - start / stop acquisition pulses
//   fifo_full, fifo_empty - FIFO status
//   rd_req                - read request from the Pi interface
//   fifo_wr, fifo_wdata   - registered FIFO write strobe and data
//   fifo_rd               - combinational FIFO read strobe (READOUT only)
//   done, busy            - record ready / not idle (registered)
//   auto_fired            - last trigger was forced by timeout (registered)
//   rec_count             - words written in the current record
//
// Build option: define CAPTURE_AUTO_EN to enable auto mode (forced trigger
// after AUTO_TIMEOUT decimated samples in ARMED). Without it, mode 10 acts
// as normal and auto_fired is held at 0.
module capture_sequencer
    import scope_pkg::*;
#(
    parameter int DATA_W       = 16,
    parameter int REC_LEN      = 512,
    parameter int AUTO_TIMEOUT = 4096
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [DATA_W-1:0]            sample,
    input  logic                         sample_valid,
    input  logic [DATA_W-1:0]            trig_level,
    input  logic                         trig_slope,
    input  logic [5:0]                   time_scale,
    input  logic [1:0]                   mode,
    input  logic                         arm,
    input  logic                         abort,
    input  logic                         fifo_full,
    input  logic                         fifo_empty,
    input  logic                         rd_req,
    output logic                         fifo_wr,
    output logic [DATA_W-1:0]            fifo_wdata,
    output logic                         fifo_rd,
    output logic                         done,
    output logic                         busy,
    output logic                         auto_fired,
    output logic [$clog2(REC_LEN+1)-1:0] rec_count
);

    localparam int RC_W = $clog2(REC_LEN + 1);

    cap_state_t        state_q, state_d;
    cap_mode_t         mode_e;
    logic [5:0]        div;
    logic [5:0]        div_cnt_q, div_cnt_d;
    logic              run;
    logic              decim;
    logic              hit;
    logic              forced;
    logic              wr_q, wr_d;
    logic [DATA_W-1:0] wdata_q;
    logic [RC_W-1:0]   rec_cnt_q, rec_cnt_d;
    logic [RC_W-1:0]   rec_cnt_inc;
    logic              done_q, busy_q;

    assign mode_e = cap_mode_t'(mode);
    assign div    = decim_div(time_scale);

    // The divider only runs while acquiring; holding it at zero elsewhere
    // means every entry to PRIME (manual arm or automatic re-arm) starts a
    // fresh decimation phase.
    assign run   = (state_q == ST_PRIME) || (state_q == ST_ARMED) ||
                   (state_q == ST_CAPTURE);
    // >= rather than == so a time-scale change to a smaller divider
    // mid-acquisition cannot make the counter run past its wrap point.
    assign decim = run & sample_valid & (div_cnt_q >= (div - 6'd1));

    always_comb begin
        div_cnt_d = div_cnt_q;
        if (!run || decim) begin
            div_cnt_d = '0;
        end else if (sample_valid) begin
            div_cnt_d = div_cnt_q + 6'd1;
        end
    end

    trig_detect #(
        .DATA_W (DATA_W)
    ) u_trig_detect (
        .clk      (clk),
        .reset    (reset),
        .strobe_i (decim),
        .sample_i (sample),
        .level_i  (trig_level),
        .slope_i  (trig_slope),
        .hit_o    (hit)
    );

`ifdef CAPTURE_AUTO_EN
    localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);

    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
    logic            auto_q;
    logic            force_take;

    // Counts decimated samples spent in ARMED; saturates one short of the
    // timeout so the next decimated sample is the forced one.
    always_comb begin
        to_cnt_d = '0;
        if (state_q == ST_ARMED) begin
            to_cnt_d = to_cnt_q;
            if (decim && (to_cnt_q != TO_W'(AUTO_TIMEOUT - 1))) begin
                to_cnt_d = to_cnt_q + 1'b1;
            end
        end
    end

    assign forced     = (mode_e == MODE_AUTO) &&
                        (to_cnt_q == TO_W'(AUTO_TIMEOUT - 1));
    assign force_take = (state_q == ST_ARMED) & decim & ~abort & ~hit & forced;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            to_cnt_q <= '0;
            auto_q   <= 1'b0;
        end else begin
            to_cnt_q <= to_cnt_d;
            if ((state_d == ST_PRIME) && (state_q != ST_PRIME)) begin
                auto_q <= 1'b0;
            end else if (force_take) begin
                auto_q <= 1'b1;
            end
        end
    end

    assign auto_fired = auto_q;
`else
    logic unused_auto;

    assign forced      = 1'b0;
    assign auto_fired  = 1'b0;
    assign unused_auto = ^AUTO_TIMEOUT;
`endif

    assign rec_cnt_inc = rec_cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        wr_d      = 1'b0;
        rec_cnt_d = rec_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // arm beats a simultaneous abort here: abort is a no-op in IDLE.
                if (arm) begin
                    state_d   = ST_PRIME;
                    rec_cnt_d = '0;
                end
            end
            ST_PRIME: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (decim) begin
                    state_d = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (abort) begin
                    state_d = ST_IDLE;
                end else if (decim && (hit || forced)) begin
                    // The trigger sample itself is word 0 of the record.
                    wr_d      = 1'b1;
                    rec_cnt_d = RC_W'(1);
                    state_d   = (REC_LEN == 1) ? ST_READOUT : ST_CAPTURE;
                end
            end
            ST_CAPTURE: begin
                if (abort) begin
                    state_d = ST_READOUT;
                end else if (decim) begin
                    if (fifo_full) begin
                        // Sample is dropped; keep what was written so far.
                        state_d = ST_READOUT;
                    end else begin
                        wr_d      = 1'b1;
                        rec_cnt_d = rec_cnt_inc;
                        if (rec_cnt_inc == RC_W'(REC_LEN)) begin
                            state_d = ST_READOUT;
                        end
                    end
                end
            end
            ST_READOUT: begin
                if (fifo_empty && !rd_req) begin
                    if (mode_e == MODE_SINGLE) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d   = ST_PRIME;
                        rec_cnt_d = '0;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            div_cnt_q <= '0;
            wr_q      <= 1'b0;
            wdata_q   <= '0;
            rec_cnt_q <= '0;
            done_q    <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            div_cnt_q <= div_cnt_d;
            wr_q      <= wr_d;
            if (wr_d) begin
                wdata_q <= sample;
            end
            rec_cnt_q <= rec_cnt_d;
            // Status flags follow the next state so they line up with state_q.
            done_q    <= (state_d == ST_READOUT);
            busy_q    <= (state_d != ST_IDLE);
        end
    end

    assign fifo_wr    = wr_q;
    assign fifo_wdata = wdata_q;
    assign fifo_rd    = (state_q == ST_READOUT) & rd_req & ~fifo_empty;
    assign done       = done_q;
    assign busy       = busy_q;
    assign rec_count  = rec_cnt_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb_capture_sequencer: directed bench for capture_sequencer.
// Expected FIFO write data is queued by the stimulus; a separate monitor
// pops and compares on every fifo_wr. Status outputs are compared inline.
module tb_capture_sequencer;

    localparam int DATA_W       = 16;
    localparam int REC_LEN      = 8;
    localparam int AUTO_TIMEOUT = 16;
    localparam int RC_W         = $clog2(REC_LEN + 1);

    logic              clk;
    logic              reset;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic [DATA_W-1:0] trig_level;
    logic              trig_slope;
    logic [5:0]        time_scale;
    logic [1:0]        mode;
    logic              arm;
    logic              abort;
    logic              fifo_full;
    logic              fifo_empty;
    logic              rd_req;
    logic              fifo_wr;
    logic [DATA_W-1:0] fifo_wdata;
    logic              fifo_rd;
    logic              done;
    logic              busy;
    logic              auto_fired;
    logic [RC_W-1:0]   rec_count;

    int n_checks = 0;
    int n_fail   = 0;
    logic [DATA_W-1:0] exp_q[$];

    capture_sequencer #(
        .DATA_W       (DATA_W),
        .REC_LEN      (REC_LEN),
        .AUTO_TIMEOUT (AUTO_TIMEOUT)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
        .trig_level   (trig_level),
        .trig_slope   (trig_slope),
        .time_scale   (time_scale),
        .mode         (mode),
        .arm          (arm),
        .abort        (abort),
        .fifo_full    (fifo_full),
        .fifo_empty   (fifo_empty),
        .rd_req       (rd_req),
        .fifo_wr      (fifo_wr),
        .fifo_wdata   (fifo_wdata),
        .fifo_rd      (fifo_rd),
        .done         (done),
        .busy         (busy),
        .auto_fired   (auto_fired),
        .rec_count    (rec_count)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT presents must match the head of the queue.
    initial begin
        logic [DATA_W-1:0] exp_val;
        forever begin
            @(negedge clk);
            if (fifo_wr === 1'b1) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL unexpected_write: got %0d, expected no write", fifo_wdata);
                end else begin
                    exp_val = exp_q.pop_front();
                    check("fifo_wdata", {16'd0, fifo_wdata}, {16'd0, exp_val});
                end
            end
        end
    end

    // ---------------- drivers (entered and left on a negedge) ----------------
    task automatic send(input logic [DATA_W-1:0] v, input logic ab);
        sample       = v;
        sample_valid = 1'b1;
        abort        = ab;
        @(negedge clk);
        sample_valid = 1'b0;
        abort        = 1'b0;
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
    endtask

    task automatic pulse_abort();
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
    endtask

    task automatic setup(input logic [1:0] m, input logic [5:0] ts,
                         input logic [DATA_W-1:0] lvl, input logic slp);
        mode       = m;
        time_scale = ts;
        trig_level = lvl;
        trig_slope = slp;
    endtask

    // Leave READOUT in single mode and confirm return to IDLE.
    task automatic exit_single(input string name);
        mode       = 2'b01;
        fifo_empty = 1'b1;
        @(negedge clk);
        check(name, {31'd0, busy}, 32'd0);
        fifo_empty = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        reset        = 1'b1;
        sample       = '0;
        sample_valid = 1'b0;
        trig_level   = '0;
        trig_slope   = 1'b0;
        time_scale   = 6'b000001;
        mode         = 2'b00;
        arm          = 1'b0;
        abort        = 1'b0;
        fifo_full    = 1'b0;
        fifo_empty   = 1'b0;
        rd_req       = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_fifo_wr", {31'd0, fifo_wr}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_auto_fired", {31'd0, auto_fired}, 32'd0);
        check("rst_rec_count", {28'd0, rec_count}, 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Rising trigger, single mode, ramp 90..150 step 5, level 100.
        setup(2'b01, 6'b000001, 16'd100, 1'b0);
        pulse_arm();
        check("arm_busy", {31'd0, busy}, 32'd1);
        for (int i = 0; i < 8; i++) exp_q.push_back(DATA_W'(100 + 5 * i));
        for (int v = 90; v <= 150; v += 5) send(DATA_W'(v), 1'b0);
        check("rise_done", {31'd0, done}, 32'd1);
        check("rise_rec_count", {28'd0, rec_count}, 32'd8);
        rd_req = 1'b1;
        #1 check("rd_active", {31'd0, fifo_rd}, 32'd1);
        fifo_empty = 1'b1;
        #1 check("rd_empty_gated", {31'd0, fifo_rd}, 32'd0);
        @(negedge clk);
        check("hold_while_rd_req", {31'd0, done}, 32'd1);
        rd_req = 1'b0;
        @(negedge clk);
        check("single_idle_busy", {31'd0, busy}, 32'd0);
        check("single_idle_done", {31'd0, done}, 32'd0);
        fifo_empty = 1'b0;

        // Falling trigger, normal mode, ramp 80..0 step 5, level 50; twice.
        setup(2'b00, 6'b000001, 16'd50, 1'b1);
        pulse_arm();
        for (int i = 0; i < 8; i++) exp_q.push_back(DATA_W'(45 - 5 * i));
        for (int v = 80; v >= 0; v -= 5) send(DATA_W'(v), 1'b0);
        check("fall_done", {31'd0, done}, 32'd1);
        check("fall_rec_count", {28'd0, rec_count}, 32'd8);
        fifo_empty = 1'b1;
        @(negedge clk);
        check("rearm_busy", {31'd0, busy}, 32'd1);
        check("rearm_done", {31'd0, done}, 32'd0);
        check("rearm_rec_count", {28'd0, rec_count}, 32'd0);
        fifo_empty = 1'b0;
        for (int i = 0; i < 8; i++) exp_q.push_back(DATA_W'(45 - 5 * i));
        for (int v = 80; v >= 0; v -= 5) send(DATA_W'(v), 1'b0);
        check("rearm_capture_done", {31'd0, done}, 32'd1);
        exit_single("fall_exit_idle");

        // Decimation by 5: only every 5th sample is seen.
        setup(2'b01, 6'b000100, 16'd100, 1'b0);
        pulse_arm();
        for (int k = 10; k <= 45; k += 5) exp_q.push_back(DATA_W'(200 + k));
        for (int k = 1; k <= 50; k++) begin
            if (k % 5 != 0) send(DATA_W'(1000 + k), 1'b0);
            else if (k == 5) send(16'd0, 1'b0);
            else send(DATA_W'(200 + k), 1'b0);
            if (k == 10) check("div5_wr_on_10th", {31'd0, fifo_wr}, 32'd1);
            if (k == 11) check("div5_no_wr_11th", {31'd0, fifo_wr}, 32'd0);
        end
        check("div5_rec_count", {28'd0, rec_count}, 32'd8);
        exit_single("div5_exit_idle");

        // Non-one-hot time scale behaves as DIV = 1.
        setup(2'b01, 6'b000110, 16'd100, 1'b0);
        pulse_arm();
        for (int i = 0; i < 8; i++) exp_q.push_back(DATA_W'(200 + i));
        send(16'd0, 1'b0);
        for (int i = 0; i < 8; i++) send(DATA_W'(200 + i), 1'b0);
        check("nonhot_done", {31'd0, done}, 32'd1);
        exit_single("nonhot_exit_idle");

        // fifo_full mid-capture: the full-time sample is dropped.
        setup(2'b01, 6'b000001, 16'd100, 1'b0);
        pulse_arm();
        for (int i = 0; i < 3; i++) exp_q.push_back(DATA_W'(100 + i));
        send(16'd0, 1'b0);
        for (int i = 0; i < 3; i++) send(DATA_W'(100 + i), 1'b0);
        fifo_full = 1'b1;
        send(16'd103, 1'b0);
        check("full_done", {31'd0, done}, 32'd1);
        check("full_rec_count", {28'd0, rec_count}, 32'd3);
        fifo_full = 1'b0;
        send(16'd104, 1'b0);
        exit_single("full_exit_idle");

        // Abort at word 3 (coincident with a write opportunity).
        pulse_arm();
        for (int i = 0; i < 3; i++) exp_q.push_back(DATA_W'(100 + i));
        send(16'd0, 1'b0);
        for (int i = 0; i < 3; i++) send(DATA_W'(100 + i), 1'b0);
        send(16'd103, 1'b1);
        check("abort_done", {31'd0, done}, 32'd1);
        check("abort_rec_count", {28'd0, rec_count}, 32'd3);
        pulse_abort();
        check("abort_ignored_readout", {31'd0, done}, 32'd1);
        exit_single("abort_exit_idle");

        // Abort together with a trigger in ARMED: abort wins, no write.
        pulse_arm();
        send(16'd0, 1'b0);
        send(16'd200, 1'b1);
        check("abort_trig_idle", {31'd0, busy}, 32'd0);

        // arm + abort in IDLE: arm wins; abort in PRIME then returns to IDLE.
        arm   = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        arm   = 1'b0;
        abort = 1'b0;
        check("arm_beats_abort", {31'd0, busy}, 32'd1);
        pulse_abort();
        check("abort_prime_idle", {31'd0, busy}, 32'd0);

        // Reset in the middle of an acquisition.
        pulse_arm();
        send(16'd0, 1'b0);
        reset = 1'b1;
        #1 check("mid_reset_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Auto mode with a sub-threshold input.
        setup(2'b10, 6'b000001, 16'd100, 1'b0);
        pulse_arm();
`ifdef CAPTURE_AUTO_EN
        // Sample 1 primes; samples 2..17 are the 16 in ARMED, 17 is forced.
        for (int k = 17; k <= 24; k++) exp_q.push_back(DATA_W'(k));
`endif
        for (int k = 1; k <= 24; k++) send(DATA_W'(k), 1'b0);
`ifdef CAPTURE_AUTO_EN
        check("auto_fired", {31'd0, auto_fired}, 32'd1);
        check("auto_rec_count", {28'd0, rec_count}, 32'd8);
        exit_single("auto_exit_idle");
        pulse_arm();
        check("auto_fired_clear", {31'd0, auto_fired}, 32'd0);
        pulse_abort();
`else
        check("noauto_still_armed", {31'd0, busy}, 32'd1);
        check("noauto_rec_count", {28'd0, rec_count}, 32'd0);
        check("noauto_auto_fired", {31'd0, auto_fired}, 32'd0);
        pulse_abort();
        check("noauto_abort_idle", {31'd0, busy}, 32'd0);
`endif

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_sequencer.md
# capture_sequencer

Sequences one oscilloscope acquisition around the shared sample FIFO. It decimates the scaled ADC stream according to the time-scale setting and detects a rising or falling crossing of the trigger level. After the trigger it writes a fixed-length record into the FIFO, then hands the FIFO to the Pi read interface until the record is drained. It sits between the front-end scaling logic and `sync_fifo`, and owns that FIFO's `wr`/`rd` strobes.

## Interface
Parameters:
- `DATA_W`, 16: sample and trigger-level width.
- `REC_LEN`, 512: words per record; must not exceed FIFO depth.
- `AUTO_TIMEOUT`, 4096: decimated samples without a trigger before a forced trigger (used only with the macro).

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  asynchronous, active-high.
- `sample`  in  DATA_W  scaled sample, unsigned.
- `sample_valid`  in  1  one-cycle strobe per ADC sample.
- `trig_level`  in  DATA_W  trigger threshold, unsigned.
- `trig_slope`  in  1  0 = rising, 1 = falling.
- `time_scale`  in  6  one-hot decimation select.
- `mode`  in  2  00 normal, 01 single, 10 auto; 11 is treated as normal.
- `arm`  in  1  start-acquisition pulse.
- `abort`  in  1  stop-acquisition pulse.
- `fifo_full`  in  1  from `sync_fifo`.
- `fifo_empty`  in  1  from `sync_fifo`.
- `rd_req`  in  1  read request from the Pi interface.
- `fifo_wr`  out  1  FIFO write enable.
- `fifo_wdata`  out  DATA_W  FIFO write data.
- `fifo_rd`  out  1  FIFO read enable.
- `done`  out  1  record ready for readout.
- `busy`  out  1  state is not IDLE.
- `auto_fired`  out  1  the last trigger was forced by timeout.
- `rec_count`  out  $clog2(REC_LEN+1)  words written in the current record.

## Operation
- States: IDLE, PRIME, ARMED, CAPTURE, READOUT.
- Decimation divider DIV by `time_scale` bit: b0→1, b1→2, b2→5, b3→10, b4→20, b5→50; any non-one-hot value gives DIV = 1.
- A decimated sample is every DIV-th `sample_valid`. The divider counter clears on arm.
- IDLE:
  - `arm` → PRIME; `rec_count` clears to 0.
  - `arm` in any other state is ignored.
- PRIME: the first decimated sample loads the previous-sample register; → ARMED. Nothing is written.
- ARMED, per decimated sample:
  - Rising trigger: prev < `trig_level` and cur ≥ `trig_level`.
  - Falling trigger: prev ≥ `trig_level` and cur < `trig_level`.
  - On trigger: write cur, `rec_count` = 1, → CAPTURE. prev updates on every decimated sample.
- CAPTURE:
  - Write every decimated sample.
  - When `rec_count` reaches REC_LEN, or `fifo_full` is seen at a write opportunity (that sample is dropped): → READOUT.
- READOUT:
  - `done` = 1.
  - `fifo_rd` = `rd_req` & ~`fifo_empty`.
  - When `fifo_empty` = 1 and `rd_req` = 0: single → IDLE; normal/auto → PRIME (re-arm automatically). `done` drops on leaving.
- `abort`:
  - In PRIME or ARMED: → IDLE.
  - In CAPTURE: → READOUT with the partial record; `rec_count` is kept.
  - In IDLE or READOUT: ignored.
- Simultaneous events:
  - `abort` with a trigger in the same cycle: abort wins; no write.
  - `arm` together with `abort` in IDLE: arm wins.

## Timing
- Reset values: all outputs 0; state IDLE; divider and prev register cleared.
- `reset` mid-operation returns to IDLE immediately. FIFO contents are not the controller's concern.
- `fifo_wr` and `fifo_wdata` are registered: asserted the cycle after the accepted `sample_valid`, for exactly one cycle.
- Trigger-to-first-write latency is 1 clock. The trigger sample itself is word 0 of the record.
- `fifo_rd` is combinational from `rd_req`, `fifo_empty` and the state register.
- `done`, `busy`, `auto_fired` and `rec_count` are registered.
- The state transition into READOUT occurs in the same cycle as the last `fifo_wr`.

## Configuration
- `CAPTURE_AUTO_EN` defined:
  - mode 10 is live. In ARMED, a timeout counter counts decimated samples.
  - At AUTO_TIMEOUT with no trigger, the current sample is written as a forced trigger and `auto_fired` is set.
  - `auto_fired` clears on the next entry to PRIME.
- Not defined:
  - mode 10 behaves as normal; the timeout counter is absent.
  - `auto_fired` is tied to 0.

## Structure
- Shared package `scope_pkg`:
  - state enum `cap_state_t`, mode enum `cap_mode_t`;
  - `SLOPE_RISE`/`SLOPE_FALL` constants;
  - function `decim_div(time_scale)` implementing the divider table.
- Sub-module `trig_detect`: prev-sample register plus slope compare. Inputs are the decimated strobe, sample, level and slope; output is a one-cycle `hit`.

## Test plan
- Rising trigger: DIV = 1, REC_LEN = 8, level 100, ramp 90,95,…,150. Expect the first write to be 100; exactly 8 writes (100…135); `done` rises; `rec_count` = 8.
- Falling trigger: slope = 1, level 50, ramp down 80→0. Expect the first word to be the first sample < 50. Samples above 50 after arm produce no writes.
- Decimation: `time_scale` = 000100 (DIV = 5). Expect `fifo_wr` on every 5th `sample_valid` only; non-one-hot 000110 gives DIV = 1.
- Full/abort: hold `fifo_full` = 1 mid-capture → READOUT with `rec_count` = writes so far. A separate run with `abort` at word 3 → READOUT, `rec_count` = 3.
- Readout/re-arm: single mode, drain with `rd_req` → IDLE. Normal mode, drain → PRIME, and the next trigger captures again.
- Auto (macro on, AUTO_TIMEOUT = 16): constant sample 0, level 100. Expect a forced write after 16 decimated samples, `auto_fired` = 1. Macro off: no writes.
